// File: rtl/inst_loader.sv
// Instruction loader: accepts a burst of WordCount instruction words over a
// valid/ready stream and writes them to instruction memory from address 0,
// keeping a running XOR checksum and an idle watchdog while loading.
//
// state | meaning
// IDLE  | out of reset, waiting for Start
// LOAD  | accepting words; InReady high; idle watchdog running
// DONE  | all WordCount words written (or WordCount was 0)
// ERR   | idle watchdog expired before the session completed
module inst_loader #(
    parameter int A       = 16,
    parameter int W       = 9,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [A-1:0] word_count_i,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic         wr_en_o,
    output logic [A-1:0] wr_addr_o,
    output logic [W-1:0] wr_data_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         error_o,
    output logic [W-1:0] checksum_o
);

    // Idle counter must hold TIMEOUT-1; the watchdog fires on the cycle the
    // count would step onto TIMEOUT.
    localparam int            IW     = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] TO_LIM = IW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [A-1:0]   count_q, count_d;
    logic [A-1:0]   addr_q, addr_d;
    logic [IW-1:0]  idle_q, idle_d;
    logic [W-1:0]   checksum_q, checksum_d;
    logic           wr_en_q, wr_en_d;
    logic [A-1:0]   wr_addr_q, wr_addr_d;
    logic [W-1:0]   wr_data_q, wr_data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic           xfer;

    // Ready is a pure decode of state so it drops the cycle after DONE/ERR.
    assign in_ready_o = (state_q == LOAD);
    assign xfer       = in_valid_i & in_ready_o;

    // Next-state, counters and registered-output precompute.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        idle_d     = idle_q;
        checksum_d = checksum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            LOAD: begin
                if (xfer) begin
                    // A transfer always beats the watchdog.
                    wr_en_d    = 1'b1;
                    wr_addr_d  = addr_q;
                    wr_data_d  = in_data_i;
                    checksum_d = checksum_q ^ in_data_i;
                    addr_d     = addr_q + 1'b1;
                    idle_d     = '0;
                    if (addr_q == count_q - 1'b1) begin
                        state_d = DONE;
                    end
                end else if (idle_q == TO_LIM) begin
                    state_d = ERR;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: begin
                if (start_i) begin
                    count_d    = word_count_i;
                    addr_d     = '0;
                    idle_d     = '0;
                    checksum_d = '0;
                    state_d    = (word_count_i == '0) ? DONE : LOAD;
                end
            end
        endcase

        busy_d  = (state_d == LOAD);
        done_d  = (state_d == DONE);
        error_d = (state_d == ERR);
    end

    // State, counters and registered outputs; reset aborts any session.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            idle_q     <= '0;
            checksum_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            idle_q     <= idle_d;
            checksum_q <= checksum_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign checksum_o = checksum_q;

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: directed scenarios followed by randomized traffic,
// every cycle compared against a session-level reference model.
module tb_inst_loader;

    localparam int A       = 16;
    localparam int W       = 9;
    localparam int TIMEOUT = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [A-1:0] word_count;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         busy;
    logic         done;
    logic         error;
    logic [W-1:0] checksum;

    int checks   = 0;
    int failures = 0;

    // Reference model: a session is "loading" until target words arrive or
    // the watchdog runs out.
    bit loading, m_done, m_err;
    int target, accepted, idle_cnt, csum;
    bit exp_wr;
    int exp_addr, exp_data;
    int writes_seen;

    inst_loader #(.A(A), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .word_count_i (word_count),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .checksum_o   (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        loading = 0; m_done = 0; m_err = 0;
        target = 0; accepted = 0; idle_cnt = 0; csum = 0;
        exp_wr = 0; exp_addr = 0; exp_data = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        exp_wr = 0;
        if (!loading) begin
            if (start) begin
                target = int'(word_count);
                accepted = 0; idle_cnt = 0; csum = 0;
                m_err = 0;
                m_done = (target == 0);
                loading = (target != 0);
            end
        end else if (in_valid) begin
            exp_wr = 1; exp_addr = accepted; exp_data = int'(in_data);
            csum = csum ^ int'(in_data);
            accepted++;
            idle_cnt = 0;
            if (accepted == target) begin
                loading = 0; m_done = 1;
            end
        end else begin
            idle_cnt++;
            if (idle_cnt == TIMEOUT) begin
                loading = 0; m_err = 1;
            end
        end
    endtask

    task automatic check_all();
        check("in_ready", 32'(in_ready), 32'(loading));
        check("busy",     32'(busy),     32'(loading));
        check("done",     32'(done),     32'(m_done));
        check("error",    32'(error),    32'(m_err));
        check("checksum", 32'(checksum), 32'(csum));
        check("wr_en",    32'(wr_en),    32'(exp_wr));
        if (exp_wr) begin
            check("wr_addr", 32'(wr_addr), 32'(exp_addr));
            check("wr_data", 32'(wr_data), 32'(exp_data));
        end
        if (wr_en === 1'b1) writes_seen++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        start = 0; in_valid = 0; in_data = '0;
    endtask

    task automatic begin_session(input int wc);
        word_count = A'(wc); start = 1; in_valid = 0;
        step();
        start = 0;
    endtask

    task automatic send_word(input int d);
        in_valid = 1; in_data = W'(d);
        step();
        in_valid = 0;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_wr_en",    32'(wr_en),    0);
        check("rst_wr_addr",  32'(wr_addr),  0);
        check("rst_wr_data",  32'(wr_data),  0);
        check("rst_busy",     32'(busy),     0);
        check("rst_done",     32'(done),     0);
        check("rst_error",    32'(error),    0);
        check("rst_checksum", 32'(checksum), 0);
    endtask

    initial begin
        int quiet;
        int dsave[3];
        model_reset();
        idle_inputs();
        word_count = '0;
        rst_n = 0;
        #2;
        check_reset_values();
        @(negedge clk);
        rst_n = 1;

        // Three words back to back; checksum 0x1A5^0x003^0x0FF = 0x159.
        begin_session(3);
        dsave[0] = 'h1A5; dsave[1] = 'h003; dsave[2] = 'h0FF;
        writes_seen = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = W'(dsave[i]);
            step();
        end
        in_valid = 0;
        check("b2b_checksum", 32'(checksum), 32'h159);
        check("b2b_done", 32'(done), 1);
        check("b2b_writes", 32'(writes_seen), 3);
        idle_cycles(2);

        // Zero-length session goes straight to DONE, never writes.
        writes_seen = 0;
        begin_session(0);
        check("zero_done", 32'(done), 1);
        idle_cycles(3);
        check("zero_writes", 32'(writes_seen), 0);
        check("zero_checksum", 32'(checksum), 0);

        // Two words with 5-cycle gaps.
        writes_seen = 0;
        begin_session(2);
        idle_cycles(5);
        send_word('h011);
        idle_cycles(5);
        send_word('h122);
        check("gap_writes", 32'(writes_seen), 2);
        check("gap_done", 32'(done), 1);

        // Watchdog: one word then silence until ERR, then restart at 0.
        begin_session(4);
        send_word('h0AB);
        idle_cycles(TIMEOUT);
        check("to_error", 32'(error), 1);
        check("to_checksum", 32'(checksum), 32'h0AB);
        idle_cycles(2);
        begin_session(1);
        send_word('h1C3);
        check("restart_done", 32'(done), 1);

        // Transfer on the last tolerated idle cycle wins over the watchdog.
        begin_session(2);
        send_word('h005);
        idle_cycles(TIMEOUT - 1);
        send_word('h00A);
        check("edge_no_error", 32'(error), 0);
        check("edge_done", 32'(done), 1);

        // Reset mid-load, with a write pending from the edge just taken.
        begin_session(4);
        send_word('h101);
        in_valid = 1; in_data = W'('h102);
        step();
        in_valid = 0;
        rst_n = 0;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        rst_n = 1;
        begin_session(4);
        for (int i = 0; i < 4; i++) send_word(i + 'h30);
        check("post_rst_done", 32'(done), 1);

        // Start with a different count during LOAD is ignored.
        begin_session(3);
        send_word('h041);
        word_count = A'(1); start = 1;
        step();
        word_count = A'(7);
        in_valid = 1; in_data = W'('h042);
        step();
        start = 0;
        check("ign_busy", 32'(busy), 1);
        send_word('h043);
        check("ign_done", 32'(done), 1);
        idle_cycles(1);

        // Randomized traffic, including starts during LOAD and timeouts.
        quiet = 0;
        for (int c = 0; c < 1500; c++) begin
            start = ($urandom_range(0, 7) == 0);
            word_count = A'($urandom_range(0, 6));
            if (quiet == 0 && $urandom_range(0, 25) == 0) quiet = $urandom_range(4, 10);
            if (quiet > 0) begin
                in_valid = 0;
                quiet--;
            end else begin
                in_valid = ($urandom_range(0, 3) != 0);
            end
            in_data = W'($urandom_range(0, 511));
            step();
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
